// File: rtl/bpred_pkg.sv
// Shared types for the branch prediction controller: default sizes, the
// controller state encoding and the in-flight entry layout.
package bpred_pkg;

  localparam int GHR_BITS_DEF = 8;
  localparam int DEPTH_DEF    = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACTIVE  = 2'd1,
    RECOVER = 2'd2
  } bpred_state_e;

  // The controller packs entries as {index, pred}, matching this layout
  typedef struct packed {
    logic [GHR_BITS_DEF-1:0] index;
    logic                    pred;
  } infl_entry_t;

endpackage

// File: rtl/bpred_infl_fifo.sv
// In-order queue of predicted branches awaiting resolution. A clear
// outranks push/pop in the same cycle. Pointers wrap modulo DEPTH.
module bpred_infl_fifo #(
  parameter  int DEPTH  = 4,
  parameter  int DATA_W = 9,
  localparam int PTR_W  = $clog2(DEPTH),
  localparam int CNT_W  = PTR_W + 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              push,
  input  logic              pop,
  input  logic              clear,
  input  logic [DATA_W-1:0] push_data,
  output logic              full,
  output logic              empty,
  output logic [CNT_W-1:0]  count,
  output logic [DATA_W-1:0] head
);

  logic [DEPTH-1:0][DATA_W-1:0] mem;
  logic [PTR_W-1:0]             wr_ptr;
  logic [PTR_W-1:0]             rd_ptr;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // DEPTH is a power of two, so the natural overflow is the wrap
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: contents are only read behind a nonzero count
  always_ff @(posedge clk) begin
    if (push && !clear) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/branch_pred_ctrl.sv
// Tracks in-flight predicted branches, keeps speculative and architectural
// global history, and emits predictor updates one cycle after each resolve.
module branch_pred_ctrl
  import bpred_pkg::*;
#(
  parameter  int GHR_BITS = GHR_BITS_DEF,
  parameter  int DEPTH    = DEPTH_DEF,
  localparam int CNT_W    = $clog2(DEPTH) + 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                alloc_valid,
  input  logic [GHR_BITS-1:0] alloc_index,
  input  logic                alloc_pred,
  output logic                alloc_ready,
  input  logic                resolve_valid,
  input  logic                resolve_taken,
  input  logic                flush,
  output logic                upd_valid,
  output logic [GHR_BITS-1:0] upd_index,
  output logic                upd_taken,
  output logic                mispredict,
  output logic [GHR_BITS-1:0] ghr_spec,
  output logic [CNT_W-1:0]    inflight_cnt,
  output logic                resolve_err
);

  bpred_state_e        state, state_nxt;
  logic [GHR_BITS-1:0] ghr_arch, ghr_arch_nxt;
  logic [GHR_BITS:0]   head;
  logic [CNT_W-1:0]    cnt_nxt;
  logic                fifo_full, fifo_empty;
  logic                res_fire, mis, push, clear;

  assign alloc_ready = (state != RECOVER) && !fifo_full;
  assign res_fire    = resolve_valid && !fifo_empty;
  assign mis         = res_fire && (head[0] != resolve_taken);
  assign clear       = mis || flush;
  // A squash in the same cycle kills the allocation that raced it
  assign push        = alloc_valid && alloc_ready && !clear;

  assign ghr_arch_nxt = res_fire ? {ghr_arch[GHR_BITS-2:0], resolve_taken} : ghr_arch;

  bpred_infl_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (GHR_BITS + 1)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .pop       (res_fire),
    .clear     (clear),
    .push_data ({alloc_index, alloc_pred}),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (inflight_cnt),
    .head      (head)
  );

  always_comb begin
    cnt_nxt = inflight_cnt;
    if (clear)                 cnt_nxt = '0;
    else if (push && !res_fire) cnt_nxt = inflight_cnt + CNT_W'(1);
    else if (res_fire && !push) cnt_nxt = inflight_cnt - CNT_W'(1);

    state_nxt = state;
    case (state)
      RECOVER: state_nxt = IDLE;
      default: begin
        if (mis)                state_nxt = RECOVER;
        else if (cnt_nxt != '0) state_nxt = ACTIVE;
        else                    state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ghr_spec <= '0;
      ghr_arch <= '0;
    end else begin
      ghr_arch <= ghr_arch_nxt;
      // On squash, speculative history restarts from the resolved history
      if (clear)     ghr_spec <= ghr_arch_nxt;
      else if (push) ghr_spec <= {ghr_spec[GHR_BITS-2:0], alloc_pred};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      upd_valid   <= 1'b0;
      upd_index   <= '0;
      upd_taken   <= 1'b0;
      mispredict  <= 1'b0;
      resolve_err <= 1'b0;
    end else begin
      upd_valid  <= res_fire;
      mispredict <= mis;
      if (res_fire) begin
        upd_index <= head[GHR_BITS:1];
        upd_taken <= resolve_taken;
      end
      if (resolve_valid && fifo_empty) resolve_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_branch_pred_ctrl.sv
// Randomized and directed bench for branch_pred_ctrl: a queue-based model
// predicts updates into a scoreboard that a separate monitor drains.
module tb_branch_pred_ctrl;

  localparam int GB = 8;
  localparam int DP = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          alloc_valid, alloc_pred, alloc_ready;
  logic [GB-1:0] alloc_index;
  logic          resolve_valid, resolve_taken, flush;
  logic          upd_valid, upd_taken, mispredict, resolve_err;
  logic [GB-1:0] upd_index, ghr_spec;
  logic [2:0]    inflight_cnt;

  branch_pred_ctrl #(.GHR_BITS(GB), .DEPTH(DP)) dut (
    .clk(clk), .reset_n(reset_n),
    .alloc_valid(alloc_valid), .alloc_index(alloc_index), .alloc_pred(alloc_pred),
    .alloc_ready(alloc_ready),
    .resolve_valid(resolve_valid), .resolve_taken(resolve_taken), .flush(flush),
    .upd_valid(upd_valid), .upd_index(upd_index), .upd_taken(upd_taken),
    .mispredict(mispredict), .ghr_spec(ghr_spec), .inflight_cnt(inflight_cnt),
    .resolve_err(resolve_err)
  );

  always #5 clk = ~clk;

  typedef struct { logic [GB-1:0] idx; logic pred; } ent_t;
  typedef struct { logic [GB-1:0] idx; logic taken; logic mis; } upd_t;

  ent_t          mq[$];
  upd_t          exp_q[$];
  logic [GB-1:0] m_spec, m_arch;
  logic          m_err, m_rec;
  int            n_chk = 0;
  int            n_fail = 0;
  upd_t          mon_e;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    exp_q.delete();
    m_spec = '0;
    m_arch = '0;
    m_err  = 1'b0;
    m_rec  = 1'b0;
  endtask

  // One cycle: compare visible state to the model, drive inputs, advance model
  task automatic step(input logic av, input logic [GB-1:0] ai, input logic ap,
                      input logic rv, input logic rt, input logic fl);
    logic rdy, mis;
    ent_t h;
    @(negedge clk);
    chk("ghr_spec", ghr_spec, m_spec);
    chk("inflight_cnt", inflight_cnt, mq.size());
    rdy = !m_rec && (mq.size() < DP);
    chk("alloc_ready", alloc_ready, rdy);
    chk("resolve_err", resolve_err, m_err);
    alloc_valid = av; alloc_index = ai; alloc_pred = ap;
    resolve_valid = rv; resolve_taken = rt; flush = fl;
    mis = 1'b0;
    if (rv && mq.size() == 0) m_err = 1'b1;
    if (rv && mq.size() > 0) begin
      h = mq.pop_front();
      mis = (h.pred != rt);
      m_arch = {m_arch[GB-2:0], rt};
      exp_q.push_back('{idx: h.idx, taken: rt, mis: mis});
    end
    if (mis || fl) begin
      mq.delete();
      m_spec = m_arch;
    end else if (av && rdy) begin
      mq.push_back('{idx: ai, pred: ap});
      m_spec = {m_spec[GB-2:0], ap};
    end
    m_rec = mis;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, '0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    alloc_valid = 0; alloc_index = '0; alloc_pred = 0;
    resolve_valid = 0; resolve_taken = 0; flush = 0;
    reset_n = 0;
    model_reset();
    @(negedge clk);
    reset_n = 1;
  endtask

  // Monitor: every update strobe must match the oldest expected update
  initial forever begin
    @(negedge clk);
    if (reset_n && upd_valid) begin
      if (exp_q.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL upd_unexpected: got upd_index %0h with no update expected", upd_index);
      end else begin
        mon_e = exp_q.pop_front();
        chk("upd_index", upd_index, mon_e.idx);
        chk("upd_taken", upd_taken, mon_e.taken);
        chk("mispredict", mispredict, mon_e.mis);
      end
    end else if (reset_n) begin
      chk("mispredict_no_upd", mispredict, 0);
    end
  end

  initial begin
    alloc_valid = 0; alloc_index = '0; alloc_pred = 0;
    resolve_valid = 0; resolve_taken = 0; flush = 0;
    reset_n = 0;
    model_reset();
    repeat (2) @(negedge clk);
    reset_n = 1;

    // Single branch, correct prediction; flush exposes architectural history
    step(1, 8'h12, 1, 0, 0, 0);
    step(0, '0, 0, 1, 1, 0);
    step(0, '0, 0, 0, 0, 1);
    idle(1);
    chk("req033_ghr_arch", ghr_spec, 8'h01);

    // Fill to DEPTH, then a fifth request must be ignored
    do_reset();
    step(1, 8'h21, 1, 0, 0, 0);
    step(1, 8'h22, 1, 0, 0, 0);
    step(1, 8'h23, 0, 0, 0, 0);
    step(1, 8'h24, 1, 0, 0, 0);
    step(1, 8'h25, 0, 0, 0, 0);
    idle(1);
    chk("req034_ghr_spec", ghr_spec, 8'h0D);
    chk("req034_cnt", inflight_cnt, 4);
    step(0, '0, 0, 1, 1, 0);
    step(0, '0, 0, 1, 1, 0);
    step(0, '0, 0, 1, 0, 0);
    step(0, '0, 0, 1, 1, 0);
    idle(2);

    // Mispredict on head squashes the rest and holds alloc for one cycle
    do_reset();
    step(1, 8'h31, 1, 0, 0, 0);
    step(1, 8'h32, 0, 0, 0, 0);
    step(1, 8'h33, 0, 0, 0, 0);
    step(1, 8'h34, 1, 1, 0, 0);
    idle(1);
    chk("req035_mis", mispredict, 1);
    chk("req035_ready_low", alloc_ready, 0);
    idle(1);
    chk("req035_ready_back", alloc_ready, 1);

    // Same-cycle allocate and correct resolve
    do_reset();
    step(1, 8'h41, 1, 0, 0, 0);
    step(1, 8'h42, 0, 0, 0, 0);
    step(1, 8'h43, 1, 1, 1, 0);
    idle(1);
    chk("req036_cnt", inflight_cnt, 2);
    chk("req036_ghr_spec", ghr_spec, 8'h05);
    idle(1);

    // Resolve on empty queue, then flush with three in flight
    do_reset();
    step(0, '0, 0, 1, 1, 0);
    idle(2);
    chk("req037_err_held", resolve_err, 1);
    step(1, 8'h51, 1, 0, 0, 0);
    step(1, 8'h52, 1, 0, 0, 0);
    step(1, 8'h53, 0, 0, 0, 0);
    step(0, '0, 0, 0, 0, 1);
    idle(1);
    chk("req037_flush_cnt", inflight_cnt, 0);
    chk("req037_flush_ghr", ghr_spec, 8'h00);

    // Asynchronous reset with entries in flight and an update pending
    do_reset();
    step(1, 8'h61, 1, 0, 0, 0);
    step(1, 8'h62, 1, 0, 0, 0);
    step(1, 8'h63, 1, 0, 0, 0);
    step(1, 8'h64, 1, 0, 0, 0);
    step(0, '0, 0, 1, 1, 0);
    @(posedge clk);
    #2;
    reset_n = 0;
    alloc_valid = 0; resolve_valid = 0; flush = 0;
    model_reset();
    #1;
    chk("req038_upd_valid", upd_valid, 0);
    chk("req038_upd_index", upd_index, 0);
    chk("req038_upd_taken", upd_taken, 0);
    chk("req038_mispredict", mispredict, 0);
    chk("req038_cnt", inflight_cnt, 0);
    chk("req038_ghr_spec", ghr_spec, 0);
    chk("req038_err", resolve_err, 0);
    @(negedge clk);
    reset_n = 1;
    idle(1);
    chk("req038_ready", alloc_ready, 1);

    // Random traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 99) < 60), GB'($urandom), 1'($urandom),
           ($urandom_range(0, 99) < 45), 1'($urandom),
           ($urandom_range(0, 99) < 2));
    end
    idle(3);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
